// File: rtl/fp_pkg.sv
// Shared binary32 types, constants and pack/unpack helpers for the FP execute slice.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned SIG_W  = MAN_W + 1;   // significand including hidden bit
    localparam int unsigned EXT_W  = SIG_W + 3;   // significand plus guard, round, sticky
    localparam int unsigned RND_W  = SIG_W + 1;   // significand plus rounding carry
    localparam int unsigned SEXP_W = 10;          // signed working exponent

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] man;      // hidden bit included; zero for zero/subnormal
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } fp_t;

    // Split a binary32 word; subnormals collapse to signed zero.
    function automatic fp_t fp_unpack(input logic [31:0] x);
        fp_t f;
        f.sign    = x[31];
        f.exp     = x[30:23];
        f.is_zero = (x[30:23] == '0);
        f.is_inf  = (x[30:23] == '1) && (x[22:0] == '0);
        f.is_nan  = (x[30:23] == '1) && (x[22:0] != '0);
        f.man     = f.is_zero ? '0 : {1'b1, x[22:0]};
        return f;
    endfunction

    // Round a normalized 1.xxx|G|R|S mantissa to nearest-even and pack,
    // saturating to infinity on overflow and flushing to zero on underflow.
    function automatic logic [31:0] round_pack(input logic                     sign,
                                               input logic signed [SEXP_W-1:0] exp,
                                               input logic [EXT_W-1:0]         mant);
        logic                     round_up;
        logic [RND_W-1:0]         rounded;
        logic signed [SEXP_W:0]   exp_r;
        logic [MAN_W-1:0]         frac;
        logic [31:0]              res;
        round_up = mant[2] & (mant[1] | mant[0] | mant[3]);
        rounded  = {1'b0, mant[EXT_W-1:3]} + RND_W'(round_up);
        exp_r    = {exp[SEXP_W-1], exp} + {{SEXP_W{1'b0}}, rounded[SIG_W]};
        frac     = rounded[SIG_W] ? rounded[SIG_W-1:1] : rounded[MAN_W-1:0];
        if (exp_r >= 11'sd255) begin
            res = {sign, POS_INF[30:0]};
        end else if (exp_r < 11'sd1) begin
            res = {sign, 31'b0};
        end else begin
            res = {sign, exp_r[EXP_W-1:0], frac};
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_div_core.sv
// Two-stage pipelined binary32 divider: 13 quotient bits per stage plus final 14, then round.
module fp_div_core
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    localparam int unsigned Q1_W  = 13;
    localparam int unsigned Q2_W  = EXT_W - Q1_W;
    localparam int unsigned REM_W = SIG_W + 1;

    fp_t                      ua;
    fp_t                      ub;
    logic                     sign_d;
    logic                     special_d;
    logic [31:0]              special_y_d;
    logic signed [SEXP_W-1:0] exp_d;
    logic [REM_W-1:0]         rem1;
    logic [Q1_W-1:0]          q1_d;

    logic                     s1_special;
    logic [31:0]              s1_special_y;
    logic                     s1_sign;
    logic signed [SEXP_W-1:0] s1_exp;
    logic [Q1_W-1:0]          s1_q;
    logic [REM_W-1:0]         s1_rem;
    logic [SIG_W-1:0]         s1_div;

    logic [REM_W-1:0]         rem2;
    logic [Q2_W-1:0]          q2;
    logic [EXT_W-1:0]         quo;
    logic [EXT_W-1:0]         man2;
    logic signed [SEXP_W-1:0] exp2;
    logic [31:0]              y_d;

    // Stage 1: classify specials, exponent difference, leading quotient bits.
    always_comb begin
        ua          = fp_unpack(a);
        ub          = fp_unpack(b);
        sign_d      = ua.sign ^ ub.sign;
        special_d   = 1'b1;
        special_y_d = '0;
        if (ua.is_nan || ub.is_nan) begin
            special_y_d = QNAN;
        end else if ((ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
            special_y_d = QNAN;
        end else if (ua.is_inf || ub.is_zero) begin
            special_y_d = {sign_d, POS_INF[30:0]};
        end else if (ub.is_inf || ua.is_zero) begin
            special_y_d = {sign_d, 31'b0};
        end else begin
            special_d = 1'b0;
        end
        exp_d = {2'b00, ua.exp} - {2'b00, ub.exp} + 10'(BIAS);
        rem1  = {1'b0, ua.man};
        q1_d  = '0;
        for (int i = Q1_W - 1; i >= 0; i--) begin
            if (rem1 >= {1'b0, ub.man}) begin
                q1_d[i] = 1'b1;
                rem1    = rem1 - {1'b0, ub.man};
            end
            rem1 = rem1 << 1;
        end
    end

    // Stage 1 register; reset parks it as a zero-valued special so nothing stale emerges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_special   <= 1'b1;
            s1_special_y <= '0;
            s1_sign      <= 1'b0;
            s1_exp       <= '0;
            s1_q         <= '0;
            s1_rem       <= '0;
            s1_div       <= '0;
        end else begin
            s1_special   <= special_d;
            s1_special_y <= special_y_d;
            s1_sign      <= sign_d;
            s1_exp       <= exp_d;
            s1_q         <= q1_d;
            s1_rem       <= rem1;
            s1_div       <= ub.man;
        end
    end

    // Stage 2: remaining quotient bits, normalize, sticky from remainder, round.
    always_comb begin
        rem2 = s1_rem;
        q2   = '0;
        for (int i = Q2_W - 1; i >= 0; i--) begin
            if (rem2 >= {1'b0, s1_div}) begin
                q2[i] = 1'b1;
                rem2  = rem2 - {1'b0, s1_div};
            end
            rem2 = rem2 << 1;
        end
        quo = {s1_q, q2};
        if (quo[EXT_W-1]) begin
            man2 = {quo[EXT_W-1:1], quo[0] | (rem2 != '0)};
            exp2 = s1_exp;
        end else begin
            man2 = {quo[EXT_W-2:0], rem2 != '0};
            exp2 = s1_exp - 10'd1;
        end
        y_d = s1_special ? s1_special_y : round_pack(s1_sign, exp2, man2);
    end

    // Stage 2 register drives the quotient output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            y <= '0;
        end else begin
            y <= y_d;
        end
    end

endmodule

// File: rtl/fp_add_div_abs.sv
// Binary32 execute slice: combinational |x1|, 1-cycle x1+x2, 2-cycle x1/x2.
module fp_add_div_abs
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] fabs_y,
    output logic [31:0] fadd_y,
    output logic [31:0] fdiv_y
);

    fp_t                      ua;
    fp_t                      ub;
    logic                     hi_sign;
    logic [EXP_W-1:0]         hi_exp;
    logic [SIG_W-1:0]         hi_man;
    logic [EXP_W-1:0]         lo_exp;
    logic [SIG_W-1:0]         lo_man;
    logic [EXP_W-1:0]         exp_diff;
    logic [EXT_W-1:0]         hi_ext;
    logic [EXT_W-1:0]         lo_ext;
    logic [EXT_W-1:0]         lo_aligned;
    logic [EXT_W:0]           sum;
    logic [4:0]               lz;
    logic [EXT_W-1:0]         norm_man;
    logic signed [SEXP_W-1:0] norm_exp;
    logic [31:0]              add_res;

    assign fabs_y = {1'b0, x1[30:0]};

    // Adder datapath: swap by magnitude, align with sticky, add/sub, normalize, round.
    always_comb begin
        ua = fp_unpack(x1);
        ub = fp_unpack(x2);
        if ({ua.exp, ua.man} >= {ub.exp, ub.man}) begin
            hi_sign = ua.sign;
            hi_exp  = ua.exp;
            hi_man  = ua.man;
            lo_exp  = ub.exp;
            lo_man  = ub.man;
        end else begin
            hi_sign = ub.sign;
            hi_exp  = ub.exp;
            hi_man  = ub.man;
            lo_exp  = ua.exp;
            lo_man  = ua.man;
        end
        exp_diff = hi_exp - lo_exp;
        hi_ext   = {hi_man, 3'b000};
        lo_ext   = {lo_man, 3'b000};
        if (exp_diff >= 8'(EXT_W)) begin
            lo_aligned = EXT_W'(lo_ext != '0);
        end else begin
            lo_aligned    = lo_ext >> exp_diff;
            lo_aligned[0] = lo_aligned[0] | ((lo_aligned << exp_diff) != lo_ext);
        end
        if (ua.sign == ub.sign) begin
            sum = {1'b0, hi_ext} + {1'b0, lo_aligned};
        end else begin
            sum = {1'b0, hi_ext} - {1'b0, lo_aligned};
        end
        lz = '0;
        for (int i = 0; i < EXT_W; i++) begin
            if (sum[i]) begin
                lz = 5'(EXT_W - 1 - i);
            end
        end
        if (sum[EXT_W]) begin
            norm_man = {sum[EXT_W:2], sum[1] | sum[0]};
            norm_exp = {2'b00, hi_exp} + 10'd1;
        end else begin
            norm_man = sum[EXT_W-1:0] << lz;
            norm_exp = {2'b00, hi_exp} - {5'b00000, lz};
        end
        if (ua.is_nan || ub.is_nan) begin
            add_res = QNAN;
        end else if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)) begin
            add_res = QNAN;
        end else if (ua.is_inf) begin
            add_res = x1;
        end else if (ub.is_inf) begin
            add_res = x2;
        end else if (ua.is_zero && ub.is_zero) begin
            add_res = {ua.sign & ub.sign, 31'b0};
        end else if (ua.is_zero) begin
            add_res = x2;
        end else if (ub.is_zero) begin
            add_res = x1;
        end else if (sum == '0) begin
            add_res = '0;
        end else begin
            add_res = round_pack(hi_sign, norm_exp, norm_man);
        end
    end

    // Single adder pipeline register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fadd_y <= '0;
        end else begin
            fadd_y <= add_res;
        end
    end

    fp_div_core u_div (
        .clk (clk),
        .rst (rst),
        .a   (x1),
        .b   (x2),
        .y   (fdiv_y)
    );

endmodule

// File: tb/tb_fp_add_div_abs.sv
// Bench for fp_add_div_abs: directed table plus random stream against a real-arithmetic model.
module tb_fp_add_div_abs;

    localparam int N_DIR = 18;
    localparam logic [31:0] QNAN_V = 32'h7FC00000;

    localparam logic [31:0] TA [N_DIR] = '{
        32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h40C00000, 32'h3F800000,
        32'h3F800000, 32'h00000000, 32'h7F7FFFFF, 32'h7F800000, 32'h80000000, 32'h7F800000,
        32'h3F800000, 32'h00000000, 32'h00000001, 32'h00800000, 32'h7F000000, 32'hFFC00000};
    localparam logic [31:0] TB [N_DIR] = '{
        32'h40000000, 32'hBF800000, 32'h33800000, 32'h33800000, 32'h40000000, 32'h40400000,
        32'h00000000, 32'h00000000, 32'h7F7FFFFF, 32'hFF800000, 32'h80000000, 32'h3F800000,
        32'hFF800000, 32'hBF800000, 32'h80000001, 32'h7F000000, 32'h00800000, 32'h3F800000};
    localparam logic [31:0] T_ADD [N_DIR] = '{
        32'h40400000, 32'h00000000, 32'h3F800000, 32'h3F800002, 32'h41000000, 32'h40800000,
        32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h7F800000,
        32'hFF800000, 32'hBF800000, 32'h00000000, 32'h7F000000, 32'h7F000000, 32'h7FC00000};
    localparam logic [31:0] T_DIV [N_DIR] = '{
        32'h3F000000, 32'hBF800000, 32'h4B800000, 32'h4B800001, 32'h40400000, 32'h3EAAAAAB,
        32'h7F800000, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000,
        32'h80000000, 32'h80000000, 32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h7FC00000};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic [31:0] fabs_y;
    logic [31:0] fadd_y;
    logic [31:0] fdiv_y;

    int checks = 0;
    int errors = 0;

    logic [31:0] h_a [2] = '{32'h0, 32'h0};
    logic [31:0] h_b [2] = '{32'h0, 32'h0};
    logic        h_rst [2] = '{1'b0, 1'b0};
    int          edges = 0;

    always #5 clk = ~clk;

    fp_add_div_abs dut (
        .clk    (clk),
        .rst    (rst),
        .x1     (x1),
        .x2     (x2),
        .fabs_y (fabs_y),
        .fadd_y (fadd_y),
        .fdiv_y (fdiv_y)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'd0;
    endfunction

    // Exact widening of a finite binary32 to double; subnormals read as signed zero.
    function automatic real to_real(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return $bitstoreal({x[31], 63'd0});
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    // Round a double to binary32 nearest-even; overflow to inf, tiny results to signed zero.
    function automatic logic [31:0] from_real(input real r);
        logic [63:0] b;
        int          e;
        logic [52:0] m;
        logic [24:0] keep;
        logic [28:0] rest;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e    = int'(b[62:52]) - 1023 + 127;
        m    = {1'b1, b[51:0]};
        keep = {1'b0, m[52:29]};
        rest = m[28:0];
        if (rest > 29'h10000000 || (rest == 29'h10000000 && keep[0])) keep = keep + 25'd1;
        if (keep[24]) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {b[63], 8'hFF, 23'd0};
        if (e < 1) return {b[63], 31'd0};
        return {b[63], 8'(e), keep[22:0]};
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b)) return QNAN_V;
        if (is_inf(a) && is_inf(b) && (a[31] != b[31])) return QNAN_V;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        return from_real(to_real(a) + to_real(b));
    endfunction

    function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
        logic s;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b)) return QNAN_V;
        if ((is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b))) return QNAN_V;
        if (is_inf(a) || is_zero(b)) return {s, 8'hFF, 23'd0};
        if (is_inf(b) || is_zero(a)) return {s, 31'd0};
        return from_real(to_real(a) / to_real(b));
    endfunction

    function automatic logic [31:0] rand_operand(input logic [31:0] other);
        int unsigned k;
        logic [31:0] v;
        k = $urandom_range(0, 19);
        case (k)
            0: begin
                case ($urandom_range(0, 7))
                    0: v = 32'h00000000;
                    1: v = 32'h80000000;
                    2: v = 32'h7F800000;
                    3: v = 32'hFF800000;
                    4: v = 32'h7FC00000;
                    5: v = 32'h00000001;
                    6: v = 32'h7F7FFFFF;
                    default: v = 32'h00800000;
                endcase
            end
            1: v = other ^ 32'h80000000;
            2: v = other ^ 32'($urandom_range(1, 7)) ^ 32'h80000000;
            3, 4, 5, 6, 7: v = $urandom;
            default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
        endcase
        return v;
    endfunction

    task automatic apply(input logic [31:0] a, input logic [31:0] b);
        x1 = a;
        x2 = b;
        @(posedge clk);
        #2;
    endtask

    // Record what the DUT sampled at each rising edge.
    always @(posedge clk) begin
        h_a[1]   <= h_a[0];
        h_b[1]   <= h_b[0];
        h_rst[1] <= h_rst[0];
        h_a[0]   <= x1;
        h_b[0]   <= x2;
        h_rst[0] <= rst;
        edges    <= edges + 1;
    end

    // Compare every cycle against the model at the matching latency.
    always @(negedge clk) begin
        if (edges >= 2) begin
            check("fadd_stream", fadd_y, h_rst[0] ? model_add(h_a[0], h_b[0]) : 32'h0);
            check("fdiv_stream", fdiv_y, (h_rst[0] && h_rst[1]) ? model_div(h_a[1], h_b[1]) : 32'h0);
        end
        check("fabs_stream", fabs_y, {1'b0, x1[30:0]});
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b0;
        x1  = 32'h40C00000;
        x2  = 32'h40000000;
        repeat (3) @(posedge clk);
        #2;
        check("reset_fadd", fadd_y, 32'h0);
        check("reset_fdiv", fdiv_y, 32'h0);

        for (int i = 0; i < N_DIR; i++) begin
            check($sformatf("model_add_%0d", i), model_add(TA[i], TB[i]), T_ADD[i]);
            check($sformatf("model_div_%0d", i), model_div(TA[i], TB[i]), T_DIV[i]);
        end

        rst = 1'b1;
        x1  = 32'hC0400000;
        #1;
        check("fabs_neg", fabs_y, 32'h40400000);
        x1 = 32'h7FC00001;
        #1;
        check("fabs_nan", fabs_y, 32'h7FC00001);

        // Directed pairs back to back: sum one cycle later, quotient two.
        for (int i = 0; i < N_DIR; i++) begin
            apply(TA[i], TB[i]);
            check($sformatf("dir_add_%0d", i), fadd_y, T_ADD[i]);
            if (i > 0) check($sformatf("dir_div_%0d", i - 1), fdiv_y, T_DIV[i - 1]);
        end
        apply(32'h0, 32'h3F800000);
        check($sformatf("dir_div_%0d", N_DIR - 1), fdiv_y, T_DIV[N_DIR - 1]);

        // Reset with a division in flight; its quotient must never surface.
        apply(32'h40C00000, 32'h40000000);
        rst = 1'b0;
        apply(32'h3F800000, 32'h3F800000);
        check("rst_fadd", fadd_y, 32'h0);
        check("rst_fdiv", fdiv_y, 32'h0);
        rst = 1'b1;
        apply(32'h41000000, 32'h3F800000);
        check("rel_fadd", fadd_y, 32'h41100000);
        check("rel_fdiv_discard", fdiv_y, 32'h0);
        apply(32'h0, 32'h3F800000);
        check("rel_fdiv_fresh", fdiv_y, 32'h41000000);

        // Random stream with occasional single-cycle resets.
        b = 32'h3F800000;
        for (int n = 0; n < 3000; n++) begin
            a   = rand_operand(b);
            b   = rand_operand(a);
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            apply(a, b);
        end
        rst = 1'b1;
        apply(32'h0, 32'h0);
        apply(32'h0, 32'h0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
